// File: rtl/comparador_serial_izqder.sv
// Bit-serial MSB-first magnitude comparator front end.
// Captures A and B on an accepted start, presents one bit pair per cycle
// (a_bit/b_bit, MSB first) and tracks the running relation (y,z):
//   01 = equal so far, 10 = A>B, 11 = A<B.
// Optional build macro COMPARADOR_EARLY_EXIT_EN: leave SHIFT on the first
// differing bit instead of always consuming all N bits.
module comparador_serial_izqder #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         a_bit,
  output logic         b_bit,
  output logic         bit_valid,
  output logic         y,
  output logic         z,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] YZ_EQ = 2'b01;
  localparam logic [1:0] YZ_GT = 2'b10;
  localparam logic [1:0] YZ_LT = 2'b11;

  state_e        state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [1:0]    yz_q, yz_d;
  logic          a_bit_q, a_bit_d;
  logic          b_bit_q, b_bit_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state logic: operand capture, serial compare and shifting.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    yz_d    = yz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          yz_d    = YZ_EQ;
          idx_d   = CW'(N - 1);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Only the first differing bit decides; afterwards the code is sticky.
        if (yz_q == YZ_EQ) begin
          if (a_sh_q[N-1] && !b_sh_q[N-1]) begin
            yz_d = YZ_GT;
          end else if (!a_sh_q[N-1] && b_sh_q[N-1]) begin
            yz_d = YZ_LT;
          end else begin
            yz_d = YZ_EQ;
          end
        end else begin
          yz_d = yz_q;
        end
        a_sh_d = {a_sh_q[N-2:0], 1'b0};
        b_sh_d = {b_sh_q[N-2:0], 1'b0};
        idx_d  = idx_q - CW'(1);
        if (idx_q == '0) begin
          idx_d   = '0;
          state_d = S_DONE;
`ifdef COMPARADOR_EARLY_EXIT_EN
        end else if ((yz_q == YZ_EQ) && (yz_d != YZ_EQ)) begin
          idx_d   = '0;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-state: decoded from the upcoming state so outputs are registered.
  always_comb begin
    valid_d = (state_d == S_SHIFT);
    busy_d  = (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
    if (state_d == S_SHIFT) begin
      a_bit_d = a_sh_d[N-1];
      b_bit_d = b_sh_d[N-1];
    end else begin
      a_bit_d = 1'b0;
      b_bit_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      yz_q    <= YZ_EQ;
      a_bit_q <= 1'b0;
      b_bit_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      yz_q    <= yz_d;
      a_bit_q <= a_bit_d;
      b_bit_q <= b_bit_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_bit     = a_bit_q;
  assign b_bit     = b_bit_q;
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign y         = yz_q[1];
  assign z         = yz_q[0];

endmodule

// File: tb/tb_comparador_serial_izqder.sv
// Scoreboard bench for comparador_serial_izqder: stimulus pushes expected
// relation/latency per accepted start, a monitor checks on every done pulse.
module tb_comparador_serial_izqder;

  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         a_bit, b_bit, bit_valid, y, z, busy, done;

  comparador_serial_izqder #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .a_bit(a_bit), .b_bit(b_bit), .bit_valid(bit_valid),
    .y(y), .z(z), .busy(busy), .done(done)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   yz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] got_q[$];
  int         done_cycles[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference relation from plain integer comparison.
  function automatic logic [1:0] ref_rel(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a > b) return 2'b10;
    else if (a < b) return 2'b11;
    else return 2'b01;
  endfunction

  // Number of bits consumed before the result is final.
  function automatic int ref_bits(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef COMPARADOR_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--)
      if (a[i] != b[i]) return N - i;
`endif
    return N;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a; e.b = b; e.yz = ref_rel(a, b);
    e.lat = ref_bits(a, b) + 1;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || done) && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("wait_idle_timeout", 1, 0);
  endtask

  // mode 0: plain; 1: extra start pulse while busy; 2: operands change after capture
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
    wait_idle();
    A = a; B = b; start = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
    if (mode == 2) begin
      A = $urandom; B = $urandom;
    end
    if (mode == 1) begin
      @(negedge clk);
      start = 1'b1; A = ~a; B = a;
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    wait_idle();
  endtask

  // Monitor: collects bit pairs and checks each done against the scoreboard.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        got_q.delete();
      end else begin
        if (bit_valid) got_q.push_back({a_bit, b_bit});
        if (done) begin
          done_cycles.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("result_yz", int'({y, z}), int'(e.yz));
            chk("done_latency", cyc - e.acc, e.lat);
            ok = (got_q.size() == e.lat - 1);
            for (int i = 0; i < got_q.size() && i < N; i++)
              if (got_q[i] != {e.a[N-1-i], e.b[N-1-i]}) ok = 1'b0;
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL bitstream: got %0d pairs, A=%b B=%b expected %0d pairs MSB first",
                       got_q.size(), e.a, e.b, e.lat - 1);
            end
          end
          got_q.delete();
        end
      end
    end
  end

  initial begin
    int lat_h[4];
    int acc_h[4];
    int n;
    int g;
    int dsz;
    logic [N-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", int'({a_bit, b_bit, bit_valid, busy, done, y, z}), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(4'b1011, 4'b1011, 0);
    do_op(4'b1000, 4'b0111, 0);
    do_op(4'b0110, 4'b0111, 0);
    do_op(4'b1010, 4'b0011, 1);
    do_op(4'b1100, 4'b0011, 2);
    do_op(4'b0000, 4'b1111, 0);
    do_op(4'b1111, 4'b1111, 1);

    // Abort mid-SHIFT with reset: immediate reset values, no done afterwards
    wait_idle();
    A = 4'b1010; B = 4'b0110; start = 1'b1;
    push_exp(A, B);
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'({a_bit, b_bit, bit_valid, busy, done, y, z}), 1);
    exp_q.delete();
    dsz = done_cycles.size();
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) @(negedge clk);
    chk("no_done_after_abort", done_cycles.size(), dsz);

    // start held high: back-to-back comparisons
    wait_idle();
    start = 1'b1; n = 0; g = 0;
    while (n < 4 && g < 100) begin
      if (!busy && !done) begin
        ra = $urandom; rb = $urandom;
        A = ra; B = rb;
        push_exp(ra, rb);
        acc_h[n] = cyc;
        lat_h[n] = ref_bits(ra, rb) + 1;
        n++;
      end
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    chk("held_accept_count", n, 4);
    for (int j = 1; j < 4; j++)
      chk("held_spacing", acc_h[j] - acc_h[j-1], lat_h[j-1] + 1);
    wait_idle();

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      if ((i % 4) == 0) rb = ra;
      do_op(ra, rb, int'($urandom_range(0, 2)));
    end

    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparador_serial_izqder.md
Name: comparador_serial_izqder

Overview:
- Bit-serial, MSB-first (left-to-right) magnitude comparator. It is the sequential front end that feeds the typical comparator cell chain.
- Captures two N-bit operands and presents one bit pair per cycle on a_bit/b_bit, together with the running comparison state (y,z) in the cell's encoding.
- Produces the final relation after the last bit, using a start/busy/done handshake.

Parameters:
- N, 4, operand width in bits (N >= 2)
- CW, 3, width of the internal bit-index counter (must satisfy 2^CW > N)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a comparison; sampled only in IDLE
- A  in  N  operand A, captured on accepted start
- B  in  N  operand B, captured on accepted start
- a_bit  out  1  current A bit presented to the cell (MSB first)
- b_bit  out  1  current B bit presented to the cell
- bit_valid  out  1  a_bit/b_bit valid this cycle
- y  out  1  comparison state / result, bit y
- z  out  1  comparison state / result, bit z
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse when the result is final

Behaviour:
- Encoding of (y,z): 01 = equal so far; 10 = A>B; 11 = A<B. Code 00 never appears after reset.
- Reset (async, rst_n=0):
  - state=IDLE; shift registers = 0; index counter = 0.
  - a_bit=b_bit=bit_valid=busy=done=0; (y,z)=01.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: capture A and B into shift registers, set (y,z)=01, index=N-1, go to SHIFT.
  - The cycle start is accepted is cycle 0.
- SHIFT:
  - bit_valid=1, busy=1; a_bit/b_bit = MSB of the shift registers, i.e. operand bit [index].
  - On each clock edge, if (y,z)==01 update the state:
    - a_bit>b_bit -> 10
    - a_bit<b_bit -> 11
    - equal bits -> stays 01
  - Once (y,z) is 10 or 11 it is sticky (left-to-right rule: the first differing bit decides).
  - Shift registers shift left, index decrements.
  - When index==0 at the clock edge, go to DONE.
  - SHIFT lasts exactly N cycles.
- DONE:
  - Lasts one cycle: done=1, busy=0, bit_valid=0; y,z hold the final result. Then go to IDLE.
  - done asserts N+1 cycles after the start-accept edge.
- Results (y,z) hold in IDLE until the next accepted start.
- start while busy or in DONE is ignored; there is no queuing.
- start held high continuously restarts on every IDLE cycle, giving back-to-back comparisons every N+2 cycles.
- A/B changes after capture have no effect on a comparison in progress.
- rst_n asserted mid-comparison aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Index counter wrap-around never occurs; counter width is sized by CW.

Optional Feature:
- Macro: COMPARADOR_EARLY_EXIT_EN.
- Defined: in SHIFT, the edge on which (y,z) leaves 01 moves to DONE immediately. done then asserts k+1 cycles after start-accept, where k = number of bits consumed, counted from the MSB, up to and including the first differing bit.
  - Equal operands still take N cycles.
- Not defined: always shift all N bits, with fixed latency as above.
- Result values are identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-SHIFT (A=1010, B=0110) -> all outputs take reset values asynchronously, (y,z)=01; no done pulse after release.
- Equal: A=1011, B=1011, start pulse -> bit_valid for 4 cycles with a_bit/b_bit sequence 1,0,1,1; done 5 cycles after accept; (y,z)=01.
- Greater: A=1000, B=0111 -> (y,z)=10 from cycle 1 onward, final 10.
  - Without the macro: done at cycle 5.
  - With COMPARADOR_EARLY_EXIT_EN: done at cycle 2.
- Less at LSB: A=0110, B=0111 -> (y,z) stays 01 until the last bit, final 11, done at cycle 5 in both builds.
- Handshake: second start pulse during busy -> ignored, result unchanged; start held high -> consecutive done pulses spaced N+2=6 cycles apart.
- Operand isolation: change A/B during SHIFT (A=1100→0000, B=0011) -> result 10 computed from the captured values.
